square_orbit_anim: RTL and testbench

- Parametrised animated-square driver for the board's 8-digit, active-low seven-segment display.
- A lit square travels along the top half of the lower NUM_DIGITS digits, then returns along the bottom half.
- Adds over the previous fixed 4-digit version:
  - run-time speed (period) control;
  - direction control;
  - bounce mode;
  - a lap pulse.
- Sits directly under the board top level, driving the an/sseg pins. One digit is lit at a time, so no multiplexing is needed.

---
 rtl/square_orbit_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 40 ++++
 rtl/square_orbit_anim.sv | 132 +++++++++++++
 tb/tb_square_orbit_anim.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/square_orbit_pkg.sv
// Shared constants and types for the animated-square display driver.
// Segment patterns are active low, ordered {dp,g,f,e,d,c,b,a}.
//   SEG_TOP : upper square (a,b,f,g lit)
//   SEG_BOT : lower square (c,d,e,g lit)
//   SEG_OFF / AN_OFF : everything dark
package square_orbit_pkg;

  localparam logic [7:0] SEG_TOP = 8'b1001_1100;
  localparam logic [7:0] SEG_BOT = 8'b1010_0011;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } run_dir_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated tick generator.
// Produces a one-cycle tick every (period+1) enabled clock cycles.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (counter to 0)
//   en     : counter advances only while high; tick is forced low otherwise
//   period : cycles per tick minus 1
//   tick   : combinational, high on the cycle the counter reaches period
module tick_prescaler #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // >= rather than == so that lowering period mid-count fires on the
  // next cycle instead of waiting for the counter to wrap.
  always_comb begin
    tick  = en && (cnt_q >= period);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/square_orbit_anim.sv
// Animated square for an 8-digit active-low seven-segment display.
// A lit square walks the top half of digits 0..N-1, then returns along
// the bottom half. Positions 0..N-1 are top squares on digit p; positions
// N..2N-1 are bottom squares on digit 2N-1-p.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   enable   : 1 = animate, 0 = freeze (lap held low)
//   period   : clk cycles per step minus 1
//   dir      : circulate mode direction (0 fwd, 1 rev), sampled on ticks
//   bounce   : 0 = circulate, 1 = ping-pong, sampled on ticks
//   an, sseg : active-low anodes / segments {dp,g,f,e,d,c,b,a}
//   pos      : current position (debug view of the position register)
//   lap      : one-cycle pulse after a lap completes
module square_orbit_anim
  import square_orbit_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int PRESCALE_W = 27,
  localparam int POS_W      = $clog2(2 * NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  dir,
  input  logic                  bounce,
  output logic [7:0]            an,
  output logic [7:0]            sseg,
  output logic [POS_W-1:0]      pos,
  output logic                  lap
);

  localparam logic [POS_W-1:0] LAST = POS_W'(2 * NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] NPOS = POS_W'(NUM_DIGITS);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  logic             tick;
  logic [POS_W-1:0] pos_q,     pos_d;
  run_dir_t         run_dir_q, run_dir_d;
  logic             lap_q,     lap_d;
  logic [POS_W-1:0] digit;

  tick_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (enable),
    .period (period),
    .tick   (tick)
  );

  // Position / direction next state. Everything holds without a tick,
  // which also covers the frozen (enable=0) case since tick is gated.
  always_comb begin
    pos_d     = pos_q;
    run_dir_d = run_dir_q;
    lap_d     = 1'b0;
    if (tick) begin
      if (!bounce) begin
        // Circulate: direction reloads from dir on every tick, so leaving
        // bounce mode picks up dir immediately.
        run_dir_d = dir ? REV : FWD;
        if (run_dir_d == FWD) begin
          if (pos_q == LAST) begin
            pos_d = '0;
            lap_d = 1'b1;
          end else begin
            pos_d = pos_q + ONE;
          end
        end else begin
          if (pos_q == '0) begin
            pos_d = LAST;
            lap_d = 1'b1;
          end else begin
            pos_d = pos_q - ONE;
          end
        end
      end else begin
        // Bounce: reverse and step in the same tick at each end; only the
        // return to the start counts as a lap.
        unique case (run_dir_q)
          FWD: begin
            if (pos_q == LAST) begin
              run_dir_d = REV;
              pos_d     = LAST - ONE;
            end else begin
              pos_d = pos_q + ONE;
            end
          end
          REV: begin
            if (pos_q == '0) begin
              run_dir_d = FWD;
              pos_d     = ONE;
              lap_d     = 1'b1;
            end else begin
              pos_d = pos_q - ONE;
            end
          end
          default: begin
            run_dir_d = FWD;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q     <= '0;
      run_dir_q <= FWD;
      lap_q     <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      run_dir_q <= run_dir_d;
      lap_q     <= lap_d;
    end
  end

  // Display decode straight from the registered position. The digit index
  // is always below NUM_DIGITS, so unused anodes stay high.
  always_comb begin
    sseg  = SEG_OFF;
    digit = (pos_q < NPOS) ? pos_q : (LAST - pos_q);
    an    = AN_OFF & ~(8'd1 << digit);
    sseg  = (pos_q < NPOS) ? SEG_TOP : SEG_BOT;
  end

  assign pos = pos_q;
  assign lap = lap_q;

endmodule

// File: tb/tb_square_orbit_anim.sv
// Directed bench for square_orbit_anim: a cycle model of the N=4 build is
// compared on every cycle, with literal expectations at key points, plus
// a few literal checks on an N=8 build.
module tb_square_orbit_anim;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        rst8   = 1'b1;
  logic        enable = 1'b0;
  logic        dir    = 1'b0;
  logic        bounce = 1'b0;
  logic [26:0] period = '0;

  logic [7:0] an, sseg, an8, sseg8;
  logic [2:0] pos;
  logic [3:0] pos8;
  logic       lap, lap8;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // model state (N=4, 8 positions)
  int m_cnt = 0;
  int m_pos = 0;
  bit m_rev = 1'b0;
  bit m_lap = 1'b0;

  int exp_b[10] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  always #5 clk = ~clk;

  square_orbit_anim #(.NUM_DIGITS(4), .PRESCALE_W(27)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .dir(dir),
    .bounce(bounce), .an(an), .sseg(sseg), .pos(pos), .lap(lap)
  );

  square_orbit_anim #(.NUM_DIGITS(8), .PRESCALE_W(27)) dut8 (
    .clk(clk), .rst(rst8), .enable(enable), .period(period), .dir(dir),
    .bounce(bounce), .an(an8), .sseg(sseg8), .pos(pos8), .lap(lap8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: step the position around a ring of 8, or ping-pong
  // between 0 and 7, once per (period+1) enabled cycles.
  always @(posedge clk) begin
    m_lap = 1'b0;
    if (rst) begin
      m_cnt = 0;
      m_pos = 0;
      m_rev = 1'b0;
    end else if (enable) begin
      if (m_cnt >= int'(period)) begin
        m_cnt = 0;
        if (!bounce) begin
          m_rev = dir;
          if (!dir) begin
            m_pos = (m_pos + 1) % 8;
            m_lap = (m_pos == 0);
          end else begin
            m_lap = (m_pos == 0);
            m_pos = (m_pos + 7) % 8;
          end
        end else if (!m_rev) begin
          if (m_pos == 7) begin m_rev = 1'b1; m_pos = 6; end
          else m_pos = m_pos + 1;
        end else begin
          if (m_pos == 0) begin m_rev = 1'b0; m_pos = 1; m_lap = 1'b1; end
          else m_pos = m_pos - 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int dg;
    if (chk_on) begin
      dg = (m_pos < 4) ? m_pos : 7 - m_pos;
      chk("model_pos",  32'(pos),  32'(m_pos));
      chk("model_an",   32'(an),   32'(8'hFF & ~(8'h01 << dg)));
      chk("model_sseg", 32'(sseg), (m_pos < 4) ? 32'h9C : 32'hA3);
      chk("model_lap",  32'(lap),  32'(m_lap));
    end
  end

  initial begin
    // reset, held frozen
    repeat (2) @(negedge clk);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_an", 32'(an), 32'hFE);
    chk("rst_sseg", 32'(sseg), 32'h9C);
    chk("rst_lap", 32'(lap), 0);
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_pos", 32'(pos), 0);

    // forward circulate, period 0
    enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("fwd_pos", 32'(pos), 32'(i % 8));
      chk("fwd_lap", 32'(lap), (i == 8) ? 1 : 0);
      if (i == 4) begin
        chk("fwd_an4", 32'(an), 32'hF7);
        chk("fwd_sseg4", 32'(sseg), 32'hA3);
      end
      if (i == 7) begin
        chk("fwd_an7", 32'(an), 32'hFE);
        chk("fwd_sseg7", 32'(sseg), 32'hA3);
      end
    end

    // period 3: one step every 4 cycles
    period = 27'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("p3_wait", 32'(pos), 1);
    end
    @(negedge clk);
    chk("p3_step", 32'(pos), 2);
    repeat (2) @(negedge clk);
    chk("p3_cnt2", 32'(pos), 2);
    period = 27'd0;
    @(negedge clk);
    chk("p_lower", 32'(pos), 3);

    // back to 0, then reverse through the wrap
    repeat (5) @(negedge clk);
    chk("to_zero", 32'(pos), 0);
    dir = 1'b1;
    @(negedge clk);
    chk("rev_pos7", 32'(pos), 7);
    chk("rev_an7", 32'(an), 32'hFE);
    chk("rev_sseg7", 32'(sseg), 32'hA3);
    chk("rev_lap", 32'(lap), 1);
    @(negedge clk);
    chk("rev_pos6", 32'(pos), 6);
    chk("rev_lap6", 32'(lap), 0);

    // freeze
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("frz_pos", 32'(pos), 6);
      chk("frz_an", 32'(an), 32'hFD);
      chk("frz_lap", 32'(lap), 0);
    end

    // forward to 5, then bounce with dir noise
    enable = 1'b1;
    dir = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_bnc", 32'(pos), 5);
    bounce = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dir = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bnc_pos", 32'(pos), 32'(exp_b[i]));
      chk("bnc_lap", 32'(lap), (i == 9) ? 1 : 0);
    end

    // leaving bounce picks up dir at once
    bounce = 1'b0;
    dir = 1'b1;
    @(negedge clk);
    chk("unbnc_pos", 32'(pos), 0);
    chk("unbnc_lap", 32'(lap), 0);

    // reset mid-run
    dir = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pos", 32'(pos), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pos", 32'(pos), 1);

    // N=8 build
    rst8 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("n8_pos3", 32'(pos8), 3);
        chk("n8_an3", 32'(an8), 32'hF7);
        chk("n8_sseg3", 32'(sseg8), 32'h9C);
      end
    end
    chk("n8_pos15", 32'(pos8), 15);
    chk("n8_an15", 32'(an8), 32'hFE);
    chk("n8_sseg15", 32'(sseg8), 32'hA3);
    repeat (10) @(negedge clk);
    chk("n8_pos9", 32'(pos8), 9);
    rst8 = 1'b1;
    @(negedge clk);
    chk("n8_rst_pos", 32'(pos8), 0);
    chk("n8_rst_an", 32'(an8), 32'hFE);
    chk("n8_rst_sseg", 32'(sseg8), 32'h9C);
    chk("n8_rst_lap", 32'(lap8), 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
